// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bundle between the decode side, the ALU issue register and the ALU.
// The stage module uses the slave modport; the producer/consumer environment uses master.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] alu_r1;
    logic [XLEN-1:0] alu_r2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, alu_op, alu_r1, alu_r2, rd, rd_we, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, alu_op, alu_r1, alu_r2, rd, rd_we, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Registered ID/EX issue stage for the RV32I ALU: decodes OP/OP-IMM/LUI/AUIPC and registers one op per cycle.
// Define ALU_ISSUE_FORWARD_EN to let the forward bus override register-sourced operands at capture time.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_stage_if.slave issue_io
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } aluOp_e;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1Idx;
    logic [4:0]      rs2Idx;
    logic [4:0]      rdIdx;
    logic [XLEN-1:0] immI;
    logic [XLEN-1:0] immU;
    logic            fwdRs1;
    logic            fwdRs2;
    logic [XLEN-1:0] rs1Val;
    logic [XLEN-1:0] rs2Val;
    logic            capture;

    aluOp_e          aluOp_d,   aluOp_q;
    logic [XLEN-1:0] aluR1_d,   aluR1_q;
    logic [XLEN-1:0] aluR2_d,   aluR2_q;
    logic            rdWe_d,    rdWe_q;
    logic            illegal_d, illegal_q;
    logic [4:0]      rd_q;
    logic            outValid_q;

    assign opcode = issue_io.instr[6:0];
    assign funct3 = issue_io.instr[14:12];
    assign funct7 = issue_io.instr[31:25];
    assign rs1Idx = issue_io.instr[19:15];
    assign rs2Idx = issue_io.instr[24:20];
    assign rdIdx  = issue_io.instr[11:7];
    assign immI   = {{(XLEN-12){issue_io.instr[31]}}, issue_io.instr[31:20]};
    assign immU   = {issue_io.instr[31:12], 12'b0};

`ifdef ALU_ISSUE_FORWARD_EN
    // Only OP reads rs2 from the register file, so only OP may forward into r2.
    assign fwdRs1 = issue_io.fwd_valid && (issue_io.fwd_rd != 5'd0) && (issue_io.fwd_rd == rs1Idx);
    assign fwdRs2 = issue_io.fwd_valid && (issue_io.fwd_rd != 5'd0) && (issue_io.fwd_rd == rs2Idx)
                    && (opcode == OPC_OP);
`else
    logic unusedFwd;
    assign unusedFwd = issue_io.fwd_valid ^ (^issue_io.fwd_rd) ^ (^issue_io.fwd_data);
    assign fwdRs1    = 1'b0;
    assign fwdRs2    = 1'b0;
`endif

    assign rs1Val = fwdRs1 ? issue_io.fwd_data : issue_io.rs1_data;
    assign rs2Val = fwdRs2 ? issue_io.fwd_data : issue_io.rs2_data;

    // Decode the incoming word into the operation that would be captured this cycle.
    always_comb begin
        aluOp_d   = ALU_ADD;
        aluR1_d   = '0;
        aluR2_d   = '0;
        illegal_d = 1'b0;
        case (opcode)
            OPC_OP: begin
                aluR1_d   = rs1Val;
                aluR2_d   = rs2Val;
                illegal_d = !((funct7 == F7_ZERO) ||
                              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                case (funct3)
                    3'b000:  aluOp_d = issue_io.instr[30] ? ALU_SUB : ALU_ADD;
                    3'b001:  aluOp_d = ALU_SLL;
                    3'b010:  aluOp_d = ALU_SLT;
                    3'b011:  aluOp_d = ALU_SLTU;
                    3'b100:  aluOp_d = ALU_XOR;
                    3'b101:  aluOp_d = issue_io.instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  aluOp_d = ALU_OR;
                    default: aluOp_d = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                aluR1_d = rs1Val;
                aluR2_d = immI;
                case (funct3)
                    3'b000:  aluOp_d = ALU_ADD;
                    3'b001: begin
                        aluOp_d   = ALU_SLL;
                        illegal_d = (funct7 != F7_ZERO);
                    end
                    3'b010:  aluOp_d = ALU_SLT;
                    3'b011:  aluOp_d = ALU_SLTU;
                    3'b100:  aluOp_d = ALU_XOR;
                    3'b101: begin
                        aluOp_d   = issue_io.instr[30] ? ALU_SRA : ALU_SRL;
                        illegal_d = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    3'b110:  aluOp_d = ALU_OR;
                    default: aluOp_d = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                aluR2_d = immU;
            end
            OPC_AUIPC: begin
                aluR1_d = issue_io.pc;
                aluR2_d = immU;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
        if ((aluOp_d == ALU_SLL) || (aluOp_d == ALU_SRL) || (aluOp_d == ALU_SRA)) begin
            aluR2_d = {{(XLEN-5){1'b0}}, aluR2_d[4:0]};
        end
        rdWe_d = !illegal_d && (rdIdx != 5'd0);
    end

    assign issue_io.in_ready = !outValid_q || issue_io.out_ready;
    assign capture           = issue_io.in_valid && issue_io.in_ready;

    // Flush beats capture; payload is only loaded on a surviving capture and otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            aluOp_q    <= ALU_ADD;
            aluR1_q    <= '0;
            aluR2_q    <= '0;
            rd_q       <= 5'd0;
            rdWe_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (issue_io.flush) begin
            outValid_q <= 1'b0;
        end else if (capture) begin
            outValid_q <= 1'b1;
            aluOp_q    <= aluOp_d;
            aluR1_q    <= aluR1_d;
            aluR2_q    <= aluR2_d;
            rd_q       <= rdIdx;
            rdWe_q     <= rdWe_d;
            illegal_q  <= illegal_d;
        end else if (outValid_q && issue_io.out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign issue_io.out_valid = outValid_q;
    assign issue_io.alu_op    = aluOp_q;
    assign issue_io.alu_r1    = aluR1_q;
    assign issue_io.alu_r2    = aluR2_q;
    assign issue_io.rd        = rd_q;
    assign issue_io.rd_we     = rdWe_q;
    assign issue_io.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table streamed through a scoreboard plus
// hand-written backpressure, flush and mid-stall reset sequences.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        fwdValid;
        logic [4:0]  fwdRd;
        logic [31:0] fwdData;
        logic [4:0]  expOp;
        logic [31:0] expR1;
        logic [31:0] expR2;
        logic [4:0]  expRd;
        logic        expWe;
        logic        expIll;
        bit          opsKnown;
    } vec_t;

    localparam int NUM_VECS = 18;
`ifdef ALU_ISSUE_FORWARD_EN
    localparam logic [31:0] FWD_EXP = 32'h0000_00AA;
`else
    localparam logic [31:0] FWD_EXP = 32'd5;
`endif

    logic clk = 1'b0;
    logic rst_n;

    alu_issue_stage_if #(.XLEN(32)) issue_io ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_io (issue_io)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   lastAccept = 0;
    int   firstAccept = 0;
    int   emitBase = 0;
    bit   randomReady = 1'b0;
    vec_t vecs [NUM_VECS];
    vec_t expQ [$];
    int   emitEdges [$];
    vec_t monExp;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic compareEntry(input vec_t e);
        checkOutput("sb_rd", {27'b0, issue_io.rd}, {27'b0, e.expRd});
        checkOutput("sb_rd_we", {31'b0, issue_io.rd_we}, {31'b0, e.expWe});
        checkOutput("sb_illegal", {31'b0, issue_io.illegal}, {31'b0, e.expIll});
        if (e.opsKnown) begin
            checkOutput("sb_alu_op", {27'b0, issue_io.alu_op}, {27'b0, e.expOp});
            checkOutput("sb_alu_r1", issue_io.alu_r1, e.expR1);
            checkOutput("sb_alu_r2", issue_io.alu_r2, e.expR2);
        end
    endtask

    // An output transfer completes on the posedge following this negedge sample.
    always @(negedge clk) begin
        if (rst_n && issue_io.out_valid && issue_io.out_ready) begin
            emitEdges.push_back(cycleCnt + 1);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_emit actual=op%0d rd=%0d required=none", issue_io.alu_op, issue_io.rd);
            end else begin
                monExp = expQ.pop_front();
                compareEntry(monExp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (randomReady) issue_io.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input vec_t v, input bit holdValid);
        bit done = 1'b0;
        issue_io.instr     = v.instr;
        issue_io.pc        = v.pc;
        issue_io.rs1_data  = v.rs1;
        issue_io.rs2_data  = v.rs2;
        issue_io.fwd_valid = v.fwdValid;
        issue_io.fwd_rd    = v.fwdRd;
        issue_io.fwd_data  = v.fwdData;
        issue_io.in_valid  = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (issue_io.in_ready) begin
                expQ.push_back(v);
                done = 1'b1;
            end
            tick();
            if (done) lastAccept = cycleCnt;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept instr=0x%08h", v.instr);
        end
        if (!holdValid) issue_io.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 600 && expQ.size() != 0; c++) tick();
        tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout actual=%0d pending required=0", expQ.size());
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_valid"}, {31'b0, issue_io.out_valid}, 32'd0);
        checkOutput({tag, "_alu_op"}, {27'b0, issue_io.alu_op}, 32'd0);
        checkOutput({tag, "_alu_r1"}, issue_io.alu_r1, 32'd0);
        checkOutput({tag, "_alu_r2"}, issue_io.alu_r2, 32'd0);
        checkOutput({tag, "_rd"}, {27'b0, issue_io.rd}, 32'd0);
        checkOutput({tag, "_rd_we"}, {31'b0, issue_io.rd_we}, 32'd0);
        checkOutput({tag, "_illegal"}, {31'b0, issue_io.illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // instr, pc, rs1, rs2, fwdValid, fwdRd, fwdData, op, r1, r2, rd, we, ill, opsKnown
        vecs[0]  = '{32'h40208133, 32'h0,   32'd10,        32'd3,         1'b0, 5'd0, 32'h0,  5'd1, 32'd10,        32'd3,         5'd2,  1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h4050D093, 32'h4,   32'h80000000,  32'h77,        1'b0, 5'd0, 32'h0,  5'd7, 32'h80000000,  32'd5,         5'd1,  1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'hFFF00193, 32'h8,   32'h0,         32'h55,        1'b0, 5'd0, 32'h0,  5'd0, 32'h0,         32'hFFFFFFFF,  5'd3,  1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h12345297, 32'h100, 32'hDEAD,      32'hBEEF,      1'b0, 5'd0, 32'h0,  5'd0, 32'h100,       32'h12345000,  5'd5,  1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'hABCDE037, 32'h104, 32'h1,         32'h2,         1'b0, 5'd0, 32'h0,  5'd0, 32'h0,         32'hABCDE000,  5'd0,  1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h002093B3, 32'h0,   32'h1234,      32'hFFFFFF23,  1'b0, 5'd0, 32'h0,  5'd2, 32'h1234,      32'h3,         5'd7,  1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h8000B493, 32'h0,   32'h42,        32'h9,         1'b0, 5'd0, 32'h0,  5'd4, 32'h42,        32'hFFFFF800,  5'd9,  1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h4020D533, 32'h0,   32'hF0000000,  32'h24,        1'b0, 5'd0, 32'h0,  5'd7, 32'hF0000000,  32'h4,         5'd10, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'h0000A303, 32'h0,   32'h11,        32'h22,        1'b0, 5'd0, 32'h0,  5'd0, 32'h0,         32'h0,         5'd6,  1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h0220C433, 32'h0,   32'h11,        32'h22,        1'b0, 5'd0, 32'h0,  5'd0, 32'h0,         32'h0,         5'd8,  1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h0020F5B3, 32'h0,   32'hFF00FF00,  32'h0F0F0F0F,  1'b0, 5'd0, 32'h0,  5'd9, 32'hFF00FF00,  32'h0F0F0F0F,  5'd11, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{32'h4020E633, 32'h0,   32'h1,         32'h2,         1'b0, 5'd0, 32'h0,  5'd0, 32'h0,         32'h0,         5'd12, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'h40309693, 32'h0,   32'h1,         32'h2,         1'b0, 5'd0, 32'h0,  5'd0, 32'h0,         32'h0,         5'd13, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{32'h0020A733, 32'h0,   32'hFFFFFFFF,  32'h1,         1'b0, 5'd0, 32'h0,  5'd3, 32'hFFFFFFFF,  32'h1,         5'd14, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{32'h0020D7B3, 32'h0,   32'h80,        32'hFFFFFFE1,  1'b0, 5'd0, 32'h0,  5'd6, 32'h80,        32'h1,         5'd15, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{32'h00108233, 32'h0,   32'd5,         32'd5,         1'b1, 5'd1, 32'hAA, 5'd0, FWD_EXP,       FWD_EXP,       5'd4,  1'b1, 1'b0, 1'b1};
        vecs[16] = '{32'h00108233, 32'h0,   32'd5,         32'd5,         1'b1, 5'd0, 32'hAA, 5'd0, 32'd5,         32'd5,         5'd4,  1'b1, 1'b0, 1'b1};
        vecs[17] = '{32'h01F0D913, 32'h0,   32'h12345678,  32'h0,         1'b0, 5'd0, 32'h0,  5'd6, 32'h12345678,  32'h1F,        5'd18, 1'b1, 1'b0, 1'b1};

        issue_io.in_valid  = 1'b0;
        issue_io.instr     = 32'h0;
        issue_io.pc        = 32'h0;
        issue_io.rs1_data  = 32'h0;
        issue_io.rs2_data  = 32'h0;
        issue_io.flush     = 1'b0;
        issue_io.fwd_valid = 1'b0;
        issue_io.fwd_rd    = 5'd0;
        issue_io.fwd_data  = 32'h0;
        issue_io.out_ready = 1'b0;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        checkOutput("reset_in_ready", {31'b0, issue_io.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // SUB held under three cycles of backpressure.
        applyStimulus(vecs[0], 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {31'b0, issue_io.out_valid}, 32'd1);
            checkOutput("bp_alu_op", {27'b0, issue_io.alu_op}, 32'd1);
            checkOutput("bp_alu_r1", issue_io.alu_r1, 32'd10);
            checkOutput("bp_alu_r2", issue_io.alu_r2, 32'd3);
            checkOutput("bp_rd", {27'b0, issue_io.rd}, 32'd2);
            checkOutput("bp_rd_we", {31'b0, issue_io.rd_we}, 32'd1);
            checkOutput("bp_in_ready", {31'b0, issue_io.in_ready}, 32'd0);
            tick();
        end
        issue_io.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_release", {31'b0, issue_io.in_ready}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("bp_out_valid_after", {31'b0, issue_io.out_valid}, 32'd0);
        tick();

        // Full table back-to-back with out_ready held high.
        emitBase = emitEdges.size();
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], 1'b1);
            if (i == 0) firstAccept = lastAccept;
        end
        issue_io.in_valid = 1'b0;
        drain();
        checks++;
        if (emitEdges.size() < emitBase + 8) begin
            errors++;
            $display("[TB] FAIL stream_count actual=%0d required>=%0d", emitEdges.size() - emitBase, 8);
        end else if (emitEdges[emitBase + 7] - firstAccept + 1 != 9) begin
            errors++;
            $display("[TB] FAIL stream_cycles actual=%0d required=9", emitEdges[emitBase + 7] - firstAccept + 1);
        end

        // Same table under random backpressure and gaps.
        randomReady = 1'b1;
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], 1'($urandom_range(0, 1)));
        end
        issue_io.in_valid = 1'b0;
        drain();
        randomReady = 1'b0;
        issue_io.out_ready = 1'b1;
        tick();

        // Flush with a pending output and a same-cycle incoming instruction.
        issue_io.out_ready = 1'b0;
        applyStimulus(vecs[3], 1'b0);
        issue_io.instr    = vecs[5].instr;
        issue_io.in_valid = 1'b1;
        issue_io.flush    = 1'b1;
        tick();
        issue_io.flush    = 1'b0;
        issue_io.in_valid = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("flush_pending_out_valid", {31'b0, issue_io.out_valid}, 32'd0);
        issue_io.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            checkOutput("flush_quiet_out_valid", {31'b0, issue_io.out_valid}, 32'd0);
        end
        tick();

        // Flush discards a capture that would otherwise have happened.
        issue_io.instr    = vecs[10].instr;
        issue_io.in_valid = 1'b1;
        issue_io.flush    = 1'b1;
        @(negedge clk);
        checkOutput("flush_cap_in_ready", {31'b0, issue_io.in_ready}, 32'd1);
        tick();
        issue_io.flush    = 1'b0;
        issue_io.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_cap_out_valid", {31'b0, issue_io.out_valid}, 32'd0);
        tick();

        // Asynchronous reset in the middle of a stall.
        issue_io.out_ready = 1'b0;
        applyStimulus(vecs[1], 1'b0);
        @(negedge clk);
        checkOutput("stall_out_valid", {31'b0, issue_io.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue_io.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            checkOutput("post_rst_out_valid", {31'b0, issue_io.out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
